// File: rtl/pipeline_regs.sv
// Pipeline stage registers for IF/ID, ID/EX and EX/MEM with stall and flush.
// All outputs are registered; a stage of all zeros is the NOP encoding.
module pipeline_regs #(
  parameter int REG_W    = 16,
  parameter int INST_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int RADDR_W  = 4,
  parameter int ALUOP_W  = 8,
  parameter int ALUSEL_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_id,
  input  logic                flush,
  // IF/ID
  input  logic [ADDR_W-1:0]   if_pc,
  input  logic [INST_W-1:0]   if_inst,
  output logic [ADDR_W-1:0]   id_pc,
  output logic [INST_W-1:0]   id_inst,
  // ID/EX
  input  logic [ALUOP_W-1:0]  id_aluop,
  input  logic [ALUSEL_W-1:0] id_alusel,
  input  logic [REG_W-1:0]    id_reg1,
  input  logic [REG_W-1:0]    id_reg2,
  input  logic [RADDR_W-1:0]  id_wd,
  input  logic                id_wreg,
  output logic [ALUOP_W-1:0]  ex_aluop,
  output logic [ALUSEL_W-1:0] ex_alusel,
  output logic [REG_W-1:0]    ex_reg1,
  output logic [REG_W-1:0]    ex_reg2,
  output logic [RADDR_W-1:0]  ex_wd,
  output logic                ex_wreg,
  // EX/MEM
  input  logic [RADDR_W-1:0]  exr_wd,
  input  logic                exr_wreg,
  input  logic [REG_W-1:0]    exr_wdata,
  output logic [RADDR_W-1:0]  mem_wd,
  output logic                mem_wreg,
  output logic [REG_W-1:0]    mem_wdata
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_pc   <= '0;
      id_inst <= '0;
    end else if (flush) begin
      id_pc   <= '0;
      id_inst <= '0;
    end else if (!stall_id) begin
      id_pc   <= if_pc;
      id_inst <= if_inst;
    end
  end

  // A stalled decode stage injects a bubble into EX rather than repeating the instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_aluop  <= '0;
      ex_alusel <= '0;
      ex_reg1   <= '0;
      ex_reg2   <= '0;
      ex_wd     <= '0;
      ex_wreg   <= 1'b0;
    end else if (flush || stall_id) begin
      ex_aluop  <= '0;
      ex_alusel <= '0;
      ex_reg1   <= '0;
      ex_reg2   <= '0;
      ex_wd     <= '0;
      ex_wreg   <= 1'b0;
    end else begin
      ex_aluop  <= id_aluop;
      ex_alusel <= id_alusel;
      ex_reg1   <= id_reg1;
      ex_reg2   <= id_reg2;
      ex_wd     <= id_wd;
      ex_wreg   <= id_wreg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_wdata <= '0;
    end else if (flush) begin
      mem_wd    <= '0;
      mem_wreg  <= 1'b0;
      mem_wdata <= '0;
    end else begin
      mem_wd    <= exr_wd;
      mem_wreg  <= exr_wreg;
      mem_wdata <= exr_wdata;
    end
  end

endmodule

// File: tb/tb_pipeline_regs.sv
// Randomized self-checking bench for pipeline_regs against a stage-level reference model.
module tb_pipeline_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_id = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] if_pc = '0, if_inst = '0, id_pc, id_inst;
  logic [7:0]  id_aluop = '0, ex_aluop;
  logic [2:0]  id_alusel = '0, ex_alusel;
  logic [15:0] id_reg1 = '0, id_reg2 = '0, ex_reg1, ex_reg2;
  logic [3:0]  id_wd = '0, ex_wd;
  logic        id_wreg = 1'b0, ex_wreg;
  logic [3:0]  exr_wd = '0, mem_wd;
  logic        exr_wreg = 1'b0, mem_wreg;
  logic [15:0] exr_wdata = '0, mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one packed word per stage, in output order.
  logic [31:0] m_ifid;
  logic [47:0] m_idex;
  logic [20:0] m_exmem;

  pipeline_regs #(.REG_W(16), .INST_W(16), .ADDR_W(16), .RADDR_W(4),
                  .ALUOP_W(8), .ALUSEL_W(3)) dut (
    .clk(clk), .rst(rst), .stall_id(stall_id), .flush(flush),
    .if_pc(if_pc), .if_inst(if_inst), .id_pc(id_pc), .id_inst(id_inst),
    .id_aluop(id_aluop), .id_alusel(id_alusel), .id_reg1(id_reg1), .id_reg2(id_reg2),
    .id_wd(id_wd), .id_wreg(id_wreg),
    .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .exr_wd(exr_wd), .exr_wreg(exr_wreg), .exr_wdata(exr_wdata),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".ifid"},  {32'h0, id_pc, id_inst}, {32'h0, m_ifid});
    check({tag, ".idex"},  {16'h0, ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg},
          {16'h0, m_idex});
    check({tag, ".exmem"}, {43'h0, mem_wd, mem_wreg, mem_wdata}, {43'h0, m_exmem});
  endtask

  task automatic model_clear();
    m_ifid  = '0;
    m_idex  = '0;
    m_exmem = '0;
  endtask

  // Stage rules: flush zeros everything; stall holds IF/ID and bubbles ID/EX.
  task automatic model_edge();
    if (rst || flush) begin
      model_clear();
    end else begin
      if (!stall_id) m_ifid = {if_pc, if_inst};
      m_idex  = stall_id ? 48'h0 : {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg};
      m_exmem = {exr_wd, exr_wreg, exr_wdata};
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic drive_random();
    if_pc     = 16'($urandom);
    if_inst   = 16'($urandom);
    id_aluop  = 8'($urandom);
    id_alusel = 3'($urandom);
    id_reg1   = 16'($urandom);
    id_reg2   = 16'($urandom);
    id_wd     = 4'($urandom);
    id_wreg   = 1'($urandom);
    exr_wd    = 4'($urandom);
    exr_wreg  = 1'($urandom);
    exr_wdata = 16'($urandom);
  endtask

  initial begin
    model_clear();
    drive_random();
    if_inst = 16'h3443;
    #1 check_all("rst_t0");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 check_all("rst_hold");
    end
    #3 rst = 1'b0;
    step("rst_release");
    check("rst_release.id_inst", {48'h0, id_inst}, 64'h3443);

    // ID/EX and EX/MEM forward
    drive_random();
    id_reg1 = 16'h0003; id_reg2 = 16'h0006; id_wd = 4'h1; id_wreg = 1'b1;
    exr_wdata = 16'h0007; exr_wd = 4'h1; exr_wreg = 1'b1;
    step("fwd");
    check("fwd.ex_reg1", {48'h0, ex_reg1}, 64'h3);
    check("fwd.mem_wdata", {48'h0, mem_wdata}, 64'h7);

    // stall while fetch changes
    if_inst = 16'h3443;
    step("pre_stall");
    drive_random();
    if_inst = 16'h1234; stall_id = 1'b1;
    step("stall");
    check("stall.id_inst", {48'h0, id_inst}, 64'h3443);
    stall_id = 1'b0;
    step("stall_release");
    check("stall_release.id_inst", {48'h0, id_inst}, 64'h1234);

    // flush overrides stall
    drive_random();
    step("pre_flush");
    flush = 1'b1; stall_id = 1'b1;
    step("flush_stall");
    check("flush_stall.mem_wdata", {48'h0, mem_wdata}, 64'h0);
    flush = 1'b0; stall_id = 1'b0;

    // randomized traffic
    for (int i = 0; i < 200; i++) begin
      drive_random();
      stall_id = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      step("rand");
    end
    stall_id = 1'b0; flush = 1'b0;

    // asynchronous reset between edges
    drive_random();
    step("pre_async");
    #2 rst = 1'b1;
    model_clear();
    #1 check_all("async_rst");
    @(posedge clk);
    #1 check_all("async_rst_clk");
    #2 rst = 1'b0;
    drive_random();
    step("async_release");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_regs.md
PIPELINE_REGS -- requirements
Module: pipeline_regs

Interface
REQ-001 SHALL have parameter REG_W, default 16, meaning the data word width.
REQ-002 SHALL have parameter INST_W, default 16, meaning the instruction width.
REQ-003 SHALL have parameter ADDR_W, default 16, meaning the instruction address width.
REQ-004 SHALL have parameter RADDR_W, default 4, meaning the register-address width.
REQ-005 SHALL have parameters ALUOP_W, default 8, and ALUSEL_W, default 3, meaning the ALU opcode and ALU class widths.
REQ-006 SHALL use one clock and an asynchronous active-high reset: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-007 SHALL have the IF/ID ports: if_pc in ADDR_W; if_inst in INST_W; id_pc out ADDR_W; id_inst out INST_W.
REQ-008 SHALL have the ID/EX ports: id_aluop in ALUOP_W; id_alusel in ALUSEL_W; id_reg1 in REG_W; id_reg2 in REG_W; id_wd in RADDR_W; id_wreg in 1.
REQ-009 SHALL have the matching ID/EX outputs: ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, with the same widths as REQ-008.
REQ-010 SHALL have the EX/MEM ports: exr_wd in RADDR_W; exr_wreg in 1; exr_wdata in REG_W; mem_wd out RADDR_W; mem_wreg out 1; mem_wdata out REG_W.
REQ-011 SHALL have control inputs stall_id in 1 (hold the decode stage) and flush in 1 (discard all in-flight contents).

Function
REQ-012 SHALL register all outputs directly, with no combinational path from any input to any output.
REQ-013 SHALL update each stage on the rising clk edge, with a latency of exactly one cycle from input to output.
REQ-014 With stall_id=0 and flush=0, the IF/ID stage SHALL capture if_pc/if_inst into id_pc/id_inst on each edge.
REQ-015 With stall_id=0 and flush=0, the ID/EX stage SHALL capture all id_* inputs into the corresponding ex_* outputs on each edge.
REQ-016 With flush=0, the EX/MEM stage SHALL capture exr_wd/exr_wreg/exr_wdata into mem_wd/mem_wreg/mem_wdata on each edge, regardless of stall_id.
REQ-017 When stall_id=1 and flush=0, IF/ID SHALL hold its current contents.
REQ-018 When stall_id=1 and flush=0, ID/EX SHALL load a bubble (all ex_* outputs zero, so ex_wreg=0).
REQ-019 When flush=1 at an edge, all three stages SHALL load all-zero values; flush SHALL take priority over stall_id.
REQ-020 Control priority SHALL be rst > flush > stall_id > normal load.
REQ-021 SHALL not modify the data: values pass bit-exact with no width conversion, sign change or saturation.
REQ-022 An all-zero stage SHALL be the NOP encoding (wreg=0, aluop=0); downstream logic SHALL not write a register for it.

Reset
REQ-023 While rst=1, every output SHALL be zero immediately (asynchronous), independent of clk: id_pc, id_inst, all ex_*, mem_wd, mem_wreg and mem_wdata.
REQ-024 Outputs SHALL remain zero throughout rst=1, even with clk toggling and inputs active.
REQ-025 After rst falls, the first rising edge SHALL load the input values under normal rules.
REQ-026 Asserting rst mid-operation SHALL clear all stages at once, with no partial update.

Verification
REQ-027 Scenario, reset: rst=1 for 40 ns with 10 ns clk period and if_inst=0x3443 -> all outputs 0 throughout; on the first edge after rst falls, id_inst=0x3443 and id_pc=if_pc.
REQ-028 Scenario, ID/EX forward: id_reg1=0x0003, id_reg2=0x0006, id_wd=0x1, id_wreg=1 -> one edge later ex_reg1=0x0003, ex_reg2=0x0006, ex_wd=0x1, ex_wreg=1.
REQ-029 Scenario, EX/MEM forward: exr_wdata=0x0007, exr_wd=0x1, exr_wreg=1 -> one edge later mem_wdata=0x0007, mem_wd=0x1, mem_wreg=1.
REQ-030 Scenario, stall: stall_id=1 for one edge while if_inst changes 0x3443->0x1234 -> id_inst stays 0x3443, ex_* all 0, EX/MEM still loads; after release, id_inst=0x1234.
REQ-031 Scenario, flush with stall: flush=1 and stall_id=1 together -> every output 0 after the edge.
REQ-032 Scenario, async reset: rst pulsed between clk edges -> all outputs 0 before the next clk edge.
